// File: rtl/phase_modulate_pipe.sv
// phase_modulate_pipe: 3-stage multi-channel FM phase modulator, out = tw + tw*mod*idx with per-channel index glide.
// Optional build macro MOD_SAT_EN: clamp the result to [0, 2^NUM_BITS-1] and add a sticky sat_flag output.

module phase_modulate_pipe #(
  parameter int NUM_BITS  = 32,
  parameter int WI        = 2,
  parameter int WF        = 16,
  parameter int NUM_CH    = 4,
  parameter int IDX_W     = 8,
  parameter int IDX_F     = 4,
  parameter int RAMP_STEP = 1,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic                s_valid,
  input  logic [CH_W-1:0]     s_ch,
  input  logic [NUM_BITS-1:0] s_tuning_word,
  input  logic [WI+WF-1:0]    s_mod_signal,
  output logic                m_valid,
  output logic [CH_W-1:0]     m_ch,
  output logic [NUM_BITS-1:0] m_tuning_word
`ifdef MOD_SAT_EN
  ,
  output logic                sat_flag
`endif
);

  localparam int MW    = WI + WF;
  localparam int PR1_W = NUM_BITS + 1 + MW;   // full tw * mod product
  localparam int P1_W  = PR1_W - WF;
  localparam int PR2_W = P1_W + IDX_W + 1;    // full P1 * idx product
  localparam int P2_W  = PR2_W - IDX_F;
  localparam int S_W   = P2_W + 1;
  localparam logic [IDX_W-1:0] STEP = IDX_W'(RAMP_STEP);

  logic [IDX_W-1:0] cur_idx_q [NUM_CH];
  logic [IDX_W-1:0] cur_idx_d [NUM_CH];
  logic [IDX_W-1:0] tgt_idx_q [NUM_CH];
  logic [IDX_W-1:0] tgt_idx_d [NUM_CH];

  logic                accept;
  logic [IDX_W-1:0]    idx_sel;
  logic [PR1_W-1:0]    prod1;
  logic [PR2_W-1:0]    prod2;
  logic [S_W-1:0]      sum;
  logic [NUM_BITS-1:0] result;
  logic                unused_bits;

  logic                v1_q, v1_d, v2_q, v2_d, m_valid_q, m_valid_d;
  logic [CH_W-1:0]     ch1_q, ch1_d, ch2_q, ch2_d, m_ch_q, m_ch_d;
  logic [NUM_BITS-1:0] tw1_q, tw1_d, tw2_q, tw2_d, m_tw_q, m_tw_d;
  logic [IDX_W-1:0]    idx1_q, idx1_d;
  logic [P1_W-1:0]     p1_q, p1_d;
  logic [P2_W-1:0]     p2_q, p2_d;
`ifdef MOD_SAT_EN
  logic                neg, over, sat_flag_q, sat_flag_d;
`endif

  function automatic logic [IDX_W-1:0] glide_step(input logic [IDX_W-1:0] cur,
                                                  input logic [IDX_W-1:0] tgt);
    if (cur < tgt) return (tgt - cur > STEP) ? cur + STEP : tgt;
    else           return (cur - tgt > STEP) ? cur - STEP : tgt;
  endfunction

  // Index table: the sample reads the pre-update index; a same-cycle cfg write
  // only replaces the target (and the current value when gliding is disabled).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    accept    = s_valid && (int'(s_ch) < NUM_CH);
    idx_sel   = '0;
    cur_idx_d = cur_idx_q;
    tgt_idx_d = tgt_idx_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (CH_W'(c) == s_ch) begin
        idx_sel = cur_idx_q[c];
        if (accept) cur_idx_d[c] = glide_step(cur_idx_q[c], tgt_idx_q[c]);
      end
      if (cfg_we && CH_W'(c) == cfg_ch) begin
        tgt_idx_d[c] = cfg_idx;
        if (RAMP_STEP == 0) cur_idx_d[c] = cfg_idx;
      end
    end
  end

  // Datapath: operands are explicitly extended to the product width so the low
  // bits of the unsigned product equal the exact two's-complement product.
  always_comb begin
    v1_d   = accept;
    ch1_d  = s_ch;
    tw1_d  = s_tuning_word;
    idx1_d = idx_sel;
    prod1  = {{(PR1_W-NUM_BITS){1'b0}}, s_tuning_word}
           * {{(PR1_W-MW){s_mod_signal[MW-1]}}, s_mod_signal};
    p1_d   = prod1[PR1_W-1:WF];

    v2_d   = v1_q;
    ch2_d  = ch1_q;
    tw2_d  = tw1_q;
    prod2  = {{(PR2_W-P1_W){p1_q[P1_W-1]}}, p1_q} * {{(PR2_W-IDX_W){1'b0}}, idx1_q};
    p2_d   = prod2[PR2_W-1:IDX_F];

    sum    = {{(S_W-NUM_BITS){1'b0}}, tw2_q} + {p2_q[P2_W-1], p2_q};
`ifdef MOD_SAT_EN
    neg        = sum[S_W-1];
    over       = !neg && (|sum[S_W-2:NUM_BITS]);
    result     = neg ? '0 : (over ? '1 : sum[NUM_BITS-1:0]);
    sat_flag_d = sat_flag_q | (v2_q & (neg | over));
`else
    result     = sum[NUM_BITS-1:0];
`endif
    m_valid_d = v2_q;
    m_ch_d    = v2_q ? ch2_q : m_ch_q;
    m_tw_d    = v2_q ? result : m_tw_q;
  end

`ifdef MOD_SAT_EN
  assign unused_bits = ^{prod1[WF-1:0], prod2[IDX_F-1:0]};
`else
  assign unused_bits = ^{prod1[WF-1:0], prod2[IDX_F-1:0], sum[S_W-1:NUM_BITS]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the index tables are small flop arrays, reset so every channel starts at index 0.
      for (int c = 0; c < NUM_CH; c++) begin
        cur_idx_q[c] <= '0;
        tgt_idx_q[c] <= '0;
      end
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      m_valid_q  <= 1'b0;
      m_ch_q     <= '0;
      m_tw_q     <= '0;
`ifdef MOD_SAT_EN
      sat_flag_q <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
      cur_idx_q  <= cur_idx_d;
      tgt_idx_q  <= tgt_idx_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      m_valid_q  <= m_valid_d;
      m_ch_q     <= m_ch_d;
      m_tw_q     <= m_tw_d;
`ifdef MOD_SAT_EN
      sat_flag_q <= sat_flag_d;
`endif
    end
  end

  // Payload registers are qualified by the valids, so they need no reset.
  always_ff @(posedge clk) begin
    ch1_q  <= ch1_d;
    tw1_q  <= tw1_d;
    idx1_q <= idx1_d;
    p1_q   <= p1_d;
    ch2_q  <= ch2_d;
    tw2_q  <= tw2_d;
    p2_q   <= p2_d;
  end

  assign m_valid       = m_valid_q;
  assign m_ch          = m_ch_q;
  assign m_tuning_word = m_tw_q;
`ifdef MOD_SAT_EN
  assign sat_flag      = sat_flag_q;
`endif

endmodule

// File: tb/tb_phase_modulate_pipe.sv
// Bench for phase_modulate_pipe: dut0 (NUM_CH=3, RAMP_STEP=0) and dut1 (NUM_CH=4, RAMP_STEP=1)
// share one stimulus stream and are scored against an arithmetic reference model.
module tb_phase_modulate_pipe;

  typedef struct {
    bit          v;
    logic [1:0]  ch;
    logic [31:0] tw;
    bit          sat;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [7:0]  cfg_idx = '0;
  logic        s_valid = 1'b0;
  logic [1:0]  s_ch = '0;
  logic [31:0] s_tw = '0;
  logic [17:0] s_mod = '0;

  logic [1:0]       mv;
  logic [1:0][1:0]  mch;
  logic [1:0][31:0] mtw;
`ifdef MOD_SAT_EN
  logic [1:0]       sat_o;
`endif

  slot_t sl [2][3];
  int    cur [2][4];
  int    tgt [2][4];
  int    nch [2] = '{3, 4};
  int    stp [2] = '{0, 1};
  bit    esat [2];
  int    n_assert = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  phase_modulate_pipe #(.NUM_CH(3), .RAMP_STEP(0)) dut0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_idx(cfg_idx),
    .s_valid(s_valid), .s_ch(s_ch), .s_tuning_word(s_tw), .s_mod_signal(s_mod),
    .m_valid(mv[0]), .m_ch(mch[0]), .m_tuning_word(mtw[0])
`ifdef MOD_SAT_EN
    , .sat_flag(sat_o[0])
`endif
  );

  phase_modulate_pipe #(.NUM_CH(4), .RAMP_STEP(1)) dut1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_idx(cfg_idx),
    .s_valid(s_valid), .s_ch(s_ch), .s_tuning_word(s_tw), .s_mod_signal(s_mod),
    .m_valid(mv[1]), .m_ch(mch[1]), .m_tuning_word(mtw[1])
`ifdef MOD_SAT_EN
    , .sat_flag(sat_o[1])
`endif
  );

  // out = tw + floor(floor(tw*mod/2^16)*idx/2^4), wrapped or clamped to 32 bits
  function automatic logic [31:0] ref_out(input longint tw, input longint md, input longint idx,
                                          output bit clamp);
    longint p1, p2, s;
    logic [63:0] sv;
    p1 = (tw * md) >>> 16;
    p2 = (p1 * idx) >>> 4;
    s  = tw + p2;
    clamp = 1'b0;
`ifdef MOD_SAT_EN
    if (s < 0) begin s = 0; clamp = 1'b1; end
    else if (s > 64'h0_FFFF_FFFF) begin s = 64'h0_FFFF_FFFF; clamp = 1'b1; end
`endif
    sv = s;
    return sv[31:0];
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) sl[d][k] = '{1'b0, 2'd0, 32'd0, 1'b0};
      for (int c = 0; c < 4; c++) begin cur[d][c] = 0; tgt[d][c] = 0; end
      esat[d] = 1'b0;
    end
  endtask

  task automatic set_smp(input int ch, input logic [31:0] tw, input logic [17:0] md);
    s_valid = 1'b1; s_ch = 2'(ch); s_tw = tw; s_mod = md;
  endtask

  task automatic set_cfg(input int ch, input logic [7:0] idx);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_idx = idx;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    bit clamp;
    for (int d = 0; d < 2; d++) begin
      sl[d][2] = sl[d][1];
      sl[d][1] = sl[d][0];
      sl[d][0] = '{1'b0, 2'd0, 32'd0, 1'b0};
      if (s_valid && int'(s_ch) < nch[d]) begin
        sl[d][0].v   = 1'b1;
        sl[d][0].ch  = s_ch;
        sl[d][0].tw  = ref_out(longint'(s_tw), longint'($signed(s_mod)), longint'(cur[d][s_ch]), clamp);
        sl[d][0].sat = clamp;
        if (cur[d][s_ch] < tgt[d][s_ch])
          cur[d][s_ch] = (cur[d][s_ch] + stp[d] > tgt[d][s_ch]) ? tgt[d][s_ch] : cur[d][s_ch] + stp[d];
        else
          cur[d][s_ch] = (cur[d][s_ch] - stp[d] < tgt[d][s_ch]) ? tgt[d][s_ch] : cur[d][s_ch] - stp[d];
      end
      if (cfg_we && int'(cfg_ch) < nch[d]) begin
        tgt[d][cfg_ch] = int'(cfg_idx);
        if (stp[d] == 0) cur[d][cfg_ch] = int'(cfg_idx);
      end
    end
    if (rst) model_clear();
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      if (sl[d][2].v && sl[d][2].sat) esat[d] = 1'b1;
    s_valid = 1'b0;
    cfg_we  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_assert++;
      if (mv[d] !== 1'b0 || mch[d] !== 2'd0 || mtw[d] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset dut%0d: got v=%0b ch=%0d tw=%h, want 0/0/0", d, mv[d], mch[d], mtw[d]);
      end
`ifdef MOD_SAT_EN
      n_assert++;
      if (sat_o[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_sat dut%0d: got %0b want 0", d, sat_o[d]);
      end
`endif
    end
    model_clear();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] want;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: set_cfg(0, 8'h10);
        1: set_smp(0, 32'h1000_0000, 18'h10000);
        2: set_smp(0, 32'h1000_0000, 18'h30000);
        3: set_cfg(0, 8'h20);
        4: set_smp(0, 32'h1000_0000, 18'h08000);
        default: ;
      endcase
      tick();
      for (int d = 0; d < 2; d++) begin
        n_assert++;
        if (mv[d] !== sl[d][2].v || (sl[d][2].v && (mch[d] !== sl[d][2].ch || mtw[d] !== sl[d][2].tw))) begin
          n_fail++;
          $display("FAIL basic dut%0d cyc%0d: got v=%0b ch=%0d tw=%h, want v=%0b ch=%0d tw=%h",
                   d, i, mv[d], mch[d], mtw[d], sl[d][2].v, sl[d][2].ch, sl[d][2].tw);
        end
      end
      if (i == 3 || i == 4 || i == 6) begin
        want = (i == 4) ? 32'h0000_0000 : 32'h2000_0000;
        n_assert++;
        if (mv[0] !== 1'b1 || mch[0] !== 2'd0 || mtw[0] !== want) begin
          n_fail++;
          $display("FAIL basic_directed cyc%0d: got v=%0b ch=%0d tw=%h, want v=1 ch=0 tw=%h",
                   i, mv[0], mch[0], mtw[0], want);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: set_cfg(0, 8'h10);
        1: set_smp(0, 32'hC000_0000, 18'h10000);
        2: set_smp(0, 32'h1000_0000, 18'h20000);
        default: ;
      endcase
      tick();
      for (int d = 0; d < 2; d++) begin
        n_assert++;
        if (mv[d] !== sl[d][2].v || (sl[d][2].v && (mch[d] !== sl[d][2].ch || mtw[d] !== sl[d][2].tw))) begin
          n_fail++;
          $display("FAIL wrap dut%0d cyc%0d: got v=%0b ch=%0d tw=%h, want v=%0b ch=%0d tw=%h",
                   d, i, mv[d], mch[d], mtw[d], sl[d][2].v, sl[d][2].ch, sl[d][2].tw);
        end
      end
      if (i == 3 || i == 4) begin
`ifdef MOD_SAT_EN
        want = (i == 3) ? 32'hFFFF_FFFF : 32'h0000_0000;
`else
        want = (i == 3) ? 32'h8000_0000 : 32'hF000_0000;
`endif
        n_assert++;
        if (mv[0] !== 1'b1 || mtw[0] !== want) begin
          n_fail++;
          $display("FAIL wrap_directed cyc%0d: got v=%0b tw=%h, want v=1 tw=%h", i, mv[0], mtw[0], want);
        end
      end
    end
`ifdef MOD_SAT_EN
    n_assert++;
    if (sat_o[0] !== 1'b1 || sat_o[1] !== esat[1]) begin
      n_fail++;
      $display("FAIL sat_flag: got %0b/%0b, want 1/%0b", sat_o[0], sat_o[1], esat[1]);
    end
`endif
  endtask

  task automatic test_glide();
    int          g_k;
    logic [31:0] q2 [$];
    logic [31:0] tw_r, want;
    g_k = 0;
    for (int j = 0; j < 46; j++) begin
      if (j == 0) set_cfg(1, 8'h10);
      else if (j <= 40 && j % 2 == 1) set_smp(1, 32'h0001_0000, 18'h10000);
      else if (j <= 40) begin
        tw_r = $urandom;
        q2.push_back(tw_r);
        set_smp(2, tw_r, 18'($urandom));
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        n_assert++;
        if (mv[d] !== sl[d][2].v || (sl[d][2].v && (mch[d] !== sl[d][2].ch || mtw[d] !== sl[d][2].tw))) begin
          n_fail++;
          $display("FAIL glide dut%0d cyc%0d: got v=%0b ch=%0d tw=%h, want v=%0b ch=%0d tw=%h",
                   d, j, mv[d], mch[d], mtw[d], sl[d][2].v, sl[d][2].ch, sl[d][2].tw);
        end
      end
      if (mv[1] === 1'b1 && mch[1] === 2'd1) begin
        want = 32'h0001_0000 + 32'h1000 * ((g_k < 16) ? g_k : 16);
        n_assert++;
        if (mtw[1] !== want) begin
          n_fail++;
          $display("FAIL glide_ramp step%0d: got %h want %h", g_k, mtw[1], want);
        end
        g_k++;
      end
      if (mv[1] === 1'b1 && mch[1] === 2'd2 && q2.size() > 0) begin
        want = q2.pop_front();
        n_assert++;
        if (mtw[1] !== want) begin
          n_fail++;
          $display("FAIL glide_idle_ch: got %h want %h", mtw[1], want);
        end
      end
    end
    n_assert++;
    if (g_k != 20 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL glide_count: got %0d ramp outputs, %0d unmatched idle; want 20, 0", g_k, q2.size());
    end
  endtask

  task automatic test_back_to_back();
    int cnt [2];
    cnt[0] = 0;
    cnt[1] = 0;
    for (int j = 0; j < 12; j++) begin
      if (j < 8) set_smp(j % 4, $urandom, 18'($urandom));
      tick();
      for (int d = 0; d < 2; d++) begin
        n_assert++;
        if (mv[d] !== sl[d][2].v || (sl[d][2].v && (mch[d] !== sl[d][2].ch || mtw[d] !== sl[d][2].tw))) begin
          n_fail++;
          $display("FAIL b2b dut%0d cyc%0d: got v=%0b ch=%0d tw=%h, want v=%0b ch=%0d tw=%h",
                   d, j, mv[d], mch[d], mtw[d], sl[d][2].v, sl[d][2].ch, sl[d][2].tw);
        end
        if (mv[d] === 1'b1) begin
          n_assert++;
          if (int'(mch[d]) != cnt[d] % nch[d]) begin
            n_fail++;
            $display("FAIL b2b_order dut%0d pulse%0d: got ch=%0d want %0d", d, cnt[d], mch[d], cnt[d] % nch[d]);
          end
          cnt[d]++;
        end
      end
    end
    n_assert++;
    if (cnt[0] != 6 || cnt[1] != 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d/%0d pulses, want 6/8", cnt[0], cnt[1]);
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 300; j++) begin
      if ($urandom_range(0, 3) == 0) set_cfg($urandom_range(0, 3), 8'($urandom));
      if ($urandom_range(0, 3) != 0) set_smp($urandom_range(0, 3), $urandom, 18'($urandom));
      tick();
      for (int d = 0; d < 2; d++) begin
        n_assert++;
        if (mv[d] !== sl[d][2].v || (sl[d][2].v && (mch[d] !== sl[d][2].ch || mtw[d] !== sl[d][2].tw))) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: got v=%0b ch=%0d tw=%h, want v=%0b ch=%0d tw=%h",
                   d, j, mv[d], mch[d], mtw[d], sl[d][2].v, sl[d][2].ch, sl[d][2].tw);
        end
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_inflight();
    logic [31:0] tw_r;
    set_cfg(0, 8'h30);
    set_smp(0, $urandom, 18'($urandom));
    tick();
    set_smp(1, $urandom, 18'($urandom));
    tick();
    #2 rst = 1'b1;
    model_clear();
    #1;
    n_assert++;
    if (mv !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_async: got m_valid=%b want 00", mv);
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      n_assert++;
      if (mv !== 2'b00 || mtw[0] !== 32'd0 || mtw[1] !== 32'd0) begin
        n_fail++;
        $display("FAIL rst_hold cyc%0d: got v=%b tw=%h/%h want v=00 tw=0", j, mv, mtw[0], mtw[1]);
      end
    end
    rst = 1'b0;
    tw_r = $urandom;
    for (int j = 0; j < 4; j++) begin
      if (j == 0) set_smp(0, tw_r, 18'($urandom));
      tick();
      for (int d = 0; d < 2; d++) begin
        n_assert++;
        if (mv[d] !== sl[d][2].v || (sl[d][2].v && (mch[d] !== sl[d][2].ch || mtw[d] !== sl[d][2].tw))) begin
          n_fail++;
          $display("FAIL post_rst dut%0d cyc%0d: got v=%0b ch=%0d tw=%h, want v=%0b ch=%0d tw=%h",
                   d, j, mv[d], mch[d], mtw[d], sl[d][2].v, sl[d][2].ch, sl[d][2].tw);
        end
      end
      if (j == 2) begin
        n_assert++;
        if (mv !== 2'b11 || mtw[0] !== tw_r || mtw[1] !== tw_r) begin
          n_fail++;
          $display("FAIL post_rst_idx0: got v=%b tw=%h/%h want v=11 tw=%h", mv, mtw[0], mtw[1], tw_r);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_wrap();
    test_glide();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
